// File: rtl/rf_wport_arbiter.sv
// Arbitrates the single regfile write port: pipeline writeback wins, MDU results bypass or buffer in a FIFO.
// Grant is zero-latency; MDU is back-pressured via mdu_ready_o when the FIFO is full and not popping.
module rf_wport_arbiter #(
    parameter int XLEN       = 64,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            pipe_wen_i,
    input  logic [4:0]      pipe_rd_i,
    input  logic [XLEN-1:0] pipe_wdata_i,
    input  logic            mdu_valid_i,
    output logic            mdu_ready_o,
    input  logic [4:0]      mdu_rd_i,
    input  logic [XLEN-1:0] mdu_wdata_i,
    output logic            wen_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            hold_o,
    output logic [31:0]     pending_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]      rd_mem_q   [DEPTH];
    logic [4:0]      rd_mem_d   [DEPTH];
    logic [XLEN-1:0] data_mem_q [DEPTH];
    logic [XLEN-1:0] data_mem_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            hold_q, hold_d;

    logic pipe_act;
    logic fifo_empty;
    logic pop;
    logic bypass;
    logic push;
    logic [SW-1:0] starve_inc;

    always_comb begin
        pipe_act    = pipe_wen_i & (pipe_rd_i != 5'd0);
        fifo_empty  = (count_q == '0);
        pop         = !reset & !pipe_act & !fifo_empty;
        bypass      = !reset & !pipe_act & fifo_empty & mdu_valid_i & (mdu_rd_i != 5'd0);
        mdu_ready_o = !reset & ((count_q < CW'(DEPTH)) | pop);
        // rd=0 transfers are accepted but never stored; bypassed ones are written directly
        push        = mdu_valid_i & mdu_ready_o & (mdu_rd_i != 5'd0) & !bypass;
        starve_inc  = starve_q + SW'(1);
    end

    always_comb begin
        wen_o   = 1'b0;
        rd_o    = 5'd0;
        wdata_o = '0;
        if (!reset) begin
            if (pipe_act) begin
                wen_o   = 1'b1;
                rd_o    = pipe_rd_i;
                wdata_o = pipe_wdata_i;
            end else if (!fifo_empty) begin
                wen_o   = 1'b1;
                rd_o    = rd_mem_q[rptr_q];
                wdata_o = data_mem_q[rptr_q];
            end else if (bypass) begin
                wen_o   = 1'b1;
                rd_o    = mdu_rd_i;
                wdata_o = mdu_wdata_i;
            end
        end
    end

    always_comb begin
        pending_o = '0;
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i]) pending_o[rd_mem_q[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        vld_d      = vld_q;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        // pop before push so a full FIFO can recycle the head slot in one cycle
        if (pop) begin
            vld_d[rptr_q] = 1'b0;
            rptr_d        = rptr_q + AW'(1);
        end
        if (push) begin
            rd_mem_d[wptr_q]   = mdu_rd_i;
            data_mem_d[wptr_q] = mdu_wdata_i;
            vld_d[wptr_q]      = 1'b1;
            wptr_d             = wptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = '0;
        hold_d   = 1'b0;
        if (!fifo_empty && pipe_act) begin
            // a pipeline write during a hold cycle re-arms the hold immediately
            if (hold_q || (starve_inc == SW'(STARVE_MAX))) begin
                hold_d   = 1'b1;
                starve_d = '0;
            end else begin
                starve_d = starve_inc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q    <= '0;
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            hold_q   <= hold_d;
        end
    end

    always_ff @(posedge clock) begin
        rd_mem_q   <= rd_mem_d;
        data_mem_q <= data_mem_d;
    end

    assign hold_o = hold_q;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
module tb_rf_wport_arbiter;

    localparam int XLEN       = 64;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 8;

    logic            clock;
    logic            reset;
    logic            pipe_wen_i;
    logic [4:0]      pipe_rd_i;
    logic [XLEN-1:0] pipe_wdata_i;
    logic            mdu_valid_i;
    logic            mdu_ready_o;
    logic [4:0]      mdu_rd_i;
    logic [XLEN-1:0] mdu_wdata_i;
    logic            wen_o;
    logic [4:0]      rd_o;
    logic [XLEN-1:0] wdata_o;
    logic            hold_o;
    logic [31:0]     pending_o;

    rf_wport_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clock(clock), .reset(reset),
        .pipe_wen_i(pipe_wen_i), .pipe_rd_i(pipe_rd_i), .pipe_wdata_i(pipe_wdata_i),
        .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o),
        .mdu_rd_i(mdu_rd_i), .mdu_wdata_i(mdu_wdata_i),
        .wen_o(wen_o), .rd_o(rd_o), .wdata_o(wdata_o),
        .hold_o(hold_o), .pending_o(pending_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    typedef struct packed {
        logic            wen;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
        logic            rdy;
        logic            hold;
        logic [31:0]     pend;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    int   m_starve = 0;
    bit   m_hold   = 1'b0;
    int   errors   = 0;
    int   checks   = 0;
    bit   done     = 1'b0;

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle and push what the port should show during it.
    task automatic step(input logic rst, input logic pw, input logic [4:0] prd,
                        input logic [XLEN-1:0] pdat, input logic mv, input logic [4:0] mrd,
                        input logic [XLEN-1:0] mdat, output logic rdy);
        exp_t e;
        bit   act, popped, byp, nh;
        int   n;
        @(posedge clock);
        #1;
        reset = rst; pipe_wen_i = pw; pipe_rd_i = prd; pipe_wdata_i = pdat;
        mdu_valid_i = mv; mdu_rd_i = mrd; mdu_wdata_i = mdat;
        e = '0;
        e.hold = m_hold;
        rdy = 1'b0;
        if (rst) begin
            mq.delete();
            m_starve = 0;
            m_hold   = 1'b0;
        end else begin
            act = pw && (prd != 0);
            n = mq.size();
            popped = 1'b0;
            byp = 1'b0;
            foreach (mq[i]) e.pend[mq[i].rd] = 1'b1;
            if (act) begin
                e.wen = 1'b1; e.rd = prd; e.wdata = pdat;
            end else if (n > 0) begin
                e.wen = 1'b1; e.rd = mq[0].rd; e.wdata = mq[0].data;
                void'(mq.pop_front());
                popped = 1'b1;
            end else if (mv && mrd != 0) begin
                e.wen = 1'b1; e.rd = mrd; e.wdata = mdat;
                byp = 1'b1;
            end
            rdy = (n < DEPTH) || popped;
            e.rdy = rdy;
            if (mv && rdy && mrd != 0 && !byp) mq.push_back('{rd: mrd, data: mdat});
            nh = 1'b0;
            if (n > 0 && act) begin
                m_starve++;
                if (m_hold || m_starve == STARVE_MAX) begin
                    nh = 1'b1;
                    m_starve = 0;
                end
            end else begin
                m_starve = 0;
            end
            m_hold = nh;
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        logic r;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, r);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wen_o", XLEN'(wen_o), XLEN'(e.wen));
                chk("rd_o", XLEN'(rd_o), XLEN'(e.rd));
                chk("wdata_o", wdata_o, e.wdata);
                chk("mdu_ready_o", XLEN'(mdu_ready_o), XLEN'(e.rdy));
                chk("hold_o", XLEN'(hold_o), XLEN'(e.hold));
                chk("pending_o", XLEN'(pending_o), XLEN'(e.pend));
            end
        end
    end

    initial begin : stim
        logic r;
        logic            mv;
        logic [4:0]      mrd;
        logic [XLEN-1:0] mdat;
        reset = 1'b1; pipe_wen_i = 0; pipe_rd_i = 0; pipe_wdata_i = 0;
        mdu_valid_i = 0; mdu_rd_i = 0; mdu_wdata_i = 0;
        step(1, 0, 0, 0, 0, 0, 0, r);
        step(1, 0, 0, 0, 0, 0, 0, r);
        idle(1);

        // bypass on idle port
        step(0, 0, 0, 0, 1, 5, 64'h1234, r);
        idle(1);

        // pipe busy: x7, x8 buffered, x9 blocked until the first idle cycle
        step(0, 1, 3, 64'h33, 1, 7, 64'h77, r);
        step(0, 1, 3, 64'h34, 1, 8, 64'h88, r);
        step(0, 1, 3, 64'h35, 1, 9, 64'h99, r);
        step(0, 1, 3, 64'h36, 1, 9, 64'h99, r);
        step(0, 0, 0, 0, 1, 9, 64'h99, r);
        idle(3);

        // full FIFO, idle pipe: pop and push in the same cycle
        step(0, 1, 2, 64'h22, 1, 10, 64'hA0, r);
        step(0, 1, 2, 64'h23, 1, 11, 64'hB0, r);
        step(0, 0, 0, 0, 1, 12, 64'hC0, r);
        idle(3);

        // x0 pipeline write is idle; MDU rd=0 dropped
        step(0, 1, 2, 64'h24, 1, 4, 64'h44, r);
        step(0, 1, 0, 64'hDEAD, 0, 0, 0, r);
        step(0, 0, 0, 0, 1, 0, 64'hBEEF, r);
        idle(1);

        // starvation: 8 pipeline wins then hold, then drain
        step(0, 1, 1, 64'h11, 1, 6, 64'h66, r);
        for (int i = 0; i < STARVE_MAX; i++) step(0, 1, 1, 64'h100 + i, 0, 0, 0, r);
        idle(3);

        // protocol violation during hold re-arms it
        step(0, 1, 1, 64'h11, 1, 6, 64'h67, r);
        for (int i = 0; i < STARVE_MAX; i++) step(0, 1, 1, 64'h200 + i, 0, 0, 0, r);
        step(0, 1, 1, 64'h300, 0, 0, 0, r);
        idle(3);

        // reset discards buffered entries
        step(0, 1, 2, 64'h25, 1, 13, 64'hD0, r);
        step(0, 1, 2, 64'h26, 1, 14, 64'hE0, r);
        step(1, 0, 0, 0, 0, 0, 0, r);
        idle(3);

        // randomized traffic; MDU holds its offer until accepted
        mv = 0; mrd = 0; mdat = 0;
        for (int i = 0; i < 600; i++) begin
            logic rst, pw;
            logic [4:0] prd;
            logic [XLEN-1:0] pdat;
            if (!mv || r) begin
                mv   = ($urandom_range(0, 99) < 50);
                mrd  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                mdat = {$urandom, $urandom};
            end
            rst  = ($urandom_range(0, 99) == 0);
            pw   = m_hold ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) < 70);
            prd  = 5'($urandom_range(0, 31));
            pdat = {$urandom, $urandom};
            step(rst, pw, prd, pdat, mv, mrd, mdat, r);
        end
        idle(2);

        @(negedge clock);
        @(negedge clock);
        chk("scoreboard_drained", XLEN'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
